// File: rtl/alu_arbiter.sv
// Round-robin two-requester sequencer for a shared registered ALU.
// Response ALU_LAT+1 edges after accept (illegal code: next edge); held until rsp_ready.
module alu_arbiter #(
  parameter int W       = 48,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_ctrl,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [1:0] LAT_INIT = 2'(ALU_LAT);

  state_t       state;
  logic [1:0]   lat_cnt;
  logic         last_grant;
  logic         any_req;
  logic         gnt_id;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [3:0]   sel_ctrl;
  logic         sel_legal;

  always_comb begin
    any_req  = req0_valid | req1_valid;
    gnt_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_a    = gnt_id ? req1_a    : req0_a;
    sel_b    = gnt_id ? req1_b    : req0_b;
    sel_ctrl = gnt_id ? req1_ctrl : req0_ctrl;
    case (sel_ctrl)
      4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC: sel_legal = 1'b1;
      default:                            sel_legal = 1'b0;
    endcase
  end

  assign req0_ready = (state == IDLE) && any_req && !gnt_id;
  assign req1_ready = (state == IDLE) && any_req && gnt_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= gnt_id;
            rsp_id     <= gnt_id;
            if (sel_legal) begin
              alu_a    <= sel_a;
              alu_b    <= sel_b;
              alu_ctrl <= sel_ctrl;
              lat_cnt  <= LAT_INIT;
              state    <= EXEC;
            end else begin
              // Illegal code bypasses the ALU so its inputs stay untouched.
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        EXEC: begin
          if (lat_cnt == 2'd0) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU models, directed scenarios and randomized ops vs a reference model.
module tb_alu_arbiter;
  localparam int W = 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_ctrl, req1_ctrl;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;

  logic         t3_req0_valid, t3_req0_ready, t3_req1_valid, t3_req1_ready;
  logic [W-1:0] t3_req0_a, t3_req0_b, t3_req1_a, t3_req1_b;
  logic [3:0]   t3_req0_ctrl, t3_req1_ctrl;
  logic         t3_rsp_valid, t3_rsp_ready, t3_rsp_id, t3_rsp_zero, t3_rsp_err;
  logic [W-1:0] t3_rsp_result, t3_alu_a, t3_alu_b, t3_alu_result;
  logic [3:0]   t3_alu_ctrl;
  logic         t3_alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [W-1:0] op_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
    logic [W-1:0] r;
    r = '0;
    case (c)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h6: r = a - b;
      4'h7: r[0] = ($signed(a) < $signed(b));
      4'hC: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return (c == 4'h0) || (c == 4'h1) || (c == 4'h2) || (c == 4'h6) || (c == 4'h7) || (c == 4'hC);
  endfunction

  // Shared ALU models: one register stage, and a three-stage variant.
  always @(posedge clk) alu_result <= op_ref(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_result == '0);
  logic [W-1:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= op_ref(t3_alu_a, t3_alu_b, t3_alu_ctrl);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign t3_alu_result = p3[2];
  assign t3_alu_zero   = (t3_alu_result == '0);

  alu_arbiter #(.W(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_arbiter #(.W(W), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready), .req0_a(t3_req0_a), .req0_b(t3_req0_b),
    .req0_ctrl(t3_req0_ctrl),
    .req1_valid(t3_req1_valid), .req1_ready(t3_req1_ready), .req1_a(t3_req1_a), .req1_b(t3_req1_b),
    .req1_ctrl(t3_req1_ctrl),
    .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready), .rsp_id(t3_rsp_id), .rsp_result(t3_rsp_result),
    .rsp_zero(t3_rsp_zero), .rsp_err(t3_rsp_err),
    .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_ctrl(t3_alu_ctrl), .alu_result(t3_alu_result),
    .alu_zero(t3_alu_zero)
  );

  function automatic logic [W-1:0] rand_w();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following the accept edge.
  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                      output bit got);
    int t;
    t = 0;
    got = 1'b0;
    drive_req(id, a, b, c);
    #1;
    while (!got && t < 20) begin
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
      else begin @(negedge clk); #1; t++; end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== '0) begin
      n_bad++; $display("FAIL reset_rsp got v=%0b id=%0b r=%0h z=%0b e=%0b want all 0",
                        rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl} !== '0) begin
      n_bad++; $display("FAIL reset_alu got a=%0h b=%0h c=%0h want 0", alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk); rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL reset_first_grant got %02b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_add();
    bit got;
    int lat;
    rsp_ready = 1'b1;
    send(1'b0, 48'd5, -48'sd7, 4'h2, got);
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL add_accept got 0 want 1"); end
    n_cmp++;
    if (alu_a !== 48'd5 || alu_b !== 48'hFFFF_FFFF_FFF9 || alu_ctrl !== 4'h2) begin
      n_bad++; $display("FAIL add_alu_in got a=%0h b=%0h c=%0h want 5 fffffffffff9 2", alu_a, alu_b, alu_ctrl);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL add_latency got %0d want 2", lat); end
    n_cmp++;
    if (rsp_id !== 1'b0 || rsp_result !== 48'hFFFF_FFFF_FFFE || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL add_rsp got id=%0b r=%0h z=%0b e=%0b want 0 fffffffffffe 0 0",
                        rsp_id, rsp_result, rsp_zero, rsp_err);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_consumed got %0b want 0", rsp_valid); end
  endtask

  task automatic test_fairness();
    bit grants[$];
    int nrsp, t;
    bit gid;
    pulse_reset();
    rsp_ready = 1'b1;
    drive_req(1'b0, 48'd9, 48'd9, 4'h6);
    drive_req(1'b1, -48'sd3, 48'd2, 4'h7);
    #1;
    nrsp = 0; t = 0;
    while (nrsp < 4 && t < 80) begin
      n_cmp++;
      if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) && rsp_valid)) begin
        n_bad++; $display("FAIL fair_ready_excl got r0=%0b r1=%0b v=%0b", req0_ready, req1_ready, rsp_valid);
      end
      if (req0_ready) grants.push_back(1'b0);
      if (req1_ready) grants.push_back(1'b1);
      if (rsp_valid) begin
        gid = (nrsp < grants.size()) ? grants[nrsp] : 1'b0;
        n_cmp++;
        if (rsp_id !== gid || rsp_err !== 1'b0 ||
            rsp_result !== (gid ? 48'd1 : 48'd0) || rsp_zero !== !gid) begin
          n_bad++; $display("FAIL fair_rsp%0d got id=%0b r=%0h z=%0b want id=%0b r=%0d z=%0b",
                            nrsp, rsp_id, rsp_result, rsp_zero, gid, gid, !gid);
        end
        nrsp++;
      end
      @(negedge clk);
      if (grants.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1; t++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (nrsp !== 4 || grants.size() !== 4) begin
      n_bad++; $display("FAIL fair_count got rsp=%0d grants=%0d want 4 4", nrsp, grants.size());
    end else begin
      n_cmp++;
      if ({grants[0], grants[1], grants[2], grants[3]} !== 4'b0101) begin
        n_bad++; $display("FAIL fair_order got %0b%0b%0b%0b want 0101", grants[0], grants[1], grants[2], grants[3]);
      end
    end
  endtask

  task automatic test_illegal();
    bit got;
    logic [W-1:0] sa, sb;
    logic [3:0] sc;
    sa = alu_a; sb = alu_b; sc = alu_ctrl;
    rsp_ready = 1'b1;
    send(1'b1, rand_w(), rand_w(), 4'h5, got);
    n_cmp++;
    if (!got || rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL illegal_latency got accept=%0b v=%0b want 1 1", got, rsp_valid);
    end
    n_cmp++;
    if (rsp_id !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== '0 || rsp_zero !== 1'b0) begin
      n_bad++; $display("FAIL illegal_rsp got id=%0b e=%0b r=%0h z=%0b want 1 1 0 0",
                        rsp_id, rsp_err, rsp_result, rsp_zero);
    end
    n_cmp++;
    if (alu_a !== sa || alu_b !== sb || alu_ctrl !== sc) begin
      n_bad++; $display("FAIL illegal_alu_held got a=%0h b=%0h c=%0h want %0h %0h %0h", alu_a, alu_b, alu_ctrl, sa, sb, sc);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit got;
    int lat;
    rsp_ready = 1'b0;
    send(1'b0, 48'd0, 48'd0, 4'hC, got);
    wait_rsp(lat);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", lat); end
    drive_req(1'b1, 48'd1, 48'd2, 4'h2);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_result !== {W{1'b1}} || rsp_id !== 1'b0 || rsp_zero !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d got v=%0b r=%0h id=%0b z=%0b rdy=%0b%0b want 1 ffffffffffff 0 0 00",
                          i, rsp_valid, rsp_result, rsp_id, rsp_zero, req0_ready, req1_ready);
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got %0b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int lat;
    rsp_ready = 1'b1;
    send(1'b0, 48'd3, 48'd4, 4'h2, got);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || alu_a !== '0) begin
      n_bad++; $display("FAIL rstmid_clear got v=%0b a=%0h want 0 0", rsp_valid, alu_a);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale%0d got %0b want 0", i, rsp_valid); end
      @(negedge clk); #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rstmid_grant got %02b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0;
    send(1'b1, 48'd1, 48'd1, 4'h0, got);
    wait_rsp(lat);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstresp_clear got %0b want 0", rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic [3:0] codes [6];
    logic [W-1:0] a0, b0, a1, b1, ea, eb, er, held;
    logic [3:0] c0, c1, ec;
    bit last, gid;
    int mode, lat, hold;
    codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
    pulse_reset();
    last = 1'b1;
    for (int it = 0; it < 40; it++) begin
      a0 = rand_w(); b0 = ($urandom_range(0, 3) == 0) ? a0 : rand_w();
      a1 = rand_w(); b1 = ($urandom_range(0, 3) == 0) ? a1 : rand_w();
      c0 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 5)];
      c1 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 5)];
      mode = int'($urandom_range(0, 2));
      req0_a = a0; req0_b = b0; req0_ctrl = c0;
      req1_a = a1; req1_b = b1; req1_ctrl = c1;
      req0_valid = (mode != 1);
      req1_valid = (mode != 0);
      gid = (mode == 2) ? !last : (mode == 1);
      last = gid;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== (gid ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL rand%0d_grant got %02b want id %0b", it, {req0_ready, req1_ready}, gid);
      end
      ea = gid ? a1 : a0; eb = gid ? b1 : b0; ec = gid ? c1 : c0;
      er = is_legal(ec) ? op_ref(ea, eb, ec) : '0;
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk); #1; lat++;
      end
      hold = int'($urandom_range(0, 3));
      rsp_ready = (hold == 0);
      n_cmp++;
      if (lat !== (is_legal(ec) ? 2 : 0) || rsp_id !== gid || rsp_result !== er ||
          rsp_zero !== (is_legal(ec) && er == '0) || rsp_err !== !is_legal(ec)) begin
        n_bad++; $display("FAIL rand%0d_rsp got lat=%0d id=%0b r=%0h z=%0b e=%0b want lat=%0d id=%0b r=%0h ctrl=%0h",
                          it, lat, rsp_id, rsp_result, rsp_zero, rsp_err, is_legal(ec) ? 2 : 0, gid, er, ec);
      end
      held = rsp_result;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); #1;
        if (h == hold - 1) rsp_ready = 1'b1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_result !== held) begin
          n_bad++; $display("FAIL rand%0d_hold got v=%0b r=%0h want 1 %0h", it, rsp_valid, rsp_result, held);
        end
      end
      @(negedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rand%0d_drain got %0b want 0", it, rsp_valid); end
    end
  endtask

  task automatic test_lat3();
    int lat;
    bit stable;
    t3_rsp_ready = 1'b1;
    t3_req0_valid = 1'b1; t3_req0_a = 48'hF0F0; t3_req0_b = 48'hFF00; t3_req0_ctrl = 4'h0;
    #1;
    n_cmp++;
    if (t3_req0_ready !== 1'b1) begin n_bad++; $display("FAIL lat3_accept got %0b want 1", t3_req0_ready); end
    @(negedge clk);
    t3_req0_valid = 1'b0;
    t3_req0_a = rand_w(); t3_req0_b = rand_w();
    #1;
    lat = 0; stable = 1'b1;
    while (!t3_rsp_valid && lat < 20) begin
      if (t3_alu_a !== 48'hF0F0 || t3_alu_b !== 48'hFF00 || t3_alu_ctrl !== 4'h0) stable = 1'b0;
      @(negedge clk); #1; lat++;
    end
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL lat3_alu_stable got unstable want stable"); end
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL lat3_latency got %0d want 4", lat); end
    n_cmp++;
    if (t3_rsp_result !== 48'hF000 || t3_rsp_zero !== 1'b0 || t3_rsp_err !== 1'b0 || t3_rsp_id !== 1'b0) begin
      n_bad++; $display("FAIL lat3_rsp got r=%0h z=%0b e=%0b id=%0b want f000 0 0 0",
                        t3_rsp_result, t3_rsp_zero, t3_rsp_err, t3_rsp_id);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0; rsp_ready = 0;
    t3_req0_valid = 0; t3_req1_valid = 0; t3_req0_a = '0; t3_req0_b = '0; t3_req0_ctrl = '0;
    t3_req1_a = '0; t3_req1_b = '0; t3_req1_ctrl = '0; t3_rsp_ready = 0;
    test_reset();
    test_add();
    test_fairness();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_lat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 48-bit signed ALU, which registers its result on clk.
- Accepts one operation at a time through a valid/ready handshake and drives the ALU operand and control inputs.
- Waits out the ALU's registered latency, captures the ALU's result and zero flag, and returns them with the requester ID on a single response channel under backpressure.
- Rejects unsupported control codes without using the ALU.

Parameters:
- W, 48, operand/result width; must match the ALU.
- ALU_LAT, 1, clk edges from operands being stable at the ALU until its result is valid (1 to 3).

Ports:
- clk  in  1  clock; everything is on posedge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  W  signed operand A
- req0_b  in  W  signed operand B
- req0_ctrl  in  4  ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  W  signed ALU result
- rsp_zero  out  1  ALU zero flag
- rsp_err  out  1  unsupported control code
- alu_a  out  W  to ALU a
- alu_b  out  W  to ALU b
- alu_ctrl  out  4  to ALU control
- alu_result  in  W  from ALU result
- alu_zero  in  1  from ALU zero

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_ctrl=4'h0; lat_cnt=0; last_grant=1, so requester 0 wins first.
- Legal codes: 4'h0 and, 4'h1 or, 4'h2 add, 4'h6 sub, 4'h7 slt, 4'hC nor. All others are illegal.
- Grant (combinational, IDLE only):
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready = (state==IDLE) && granted N. It is never high outside IDLE, and both are never high together.
- IDLE, on accept edge:
  - Record id and update last_grant.
  - Legal code: latch a/b/ctrl into alu_a/alu_b/alu_ctrl, lat_cnt=ALU_LAT, go to EXEC.
  - Illegal code: go directly to RESP with rsp_err=1, rsp_result=0, rsp_zero=0. ALU outputs are unchanged.
- EXEC:
  - alu_a, alu_b and alu_ctrl are held stable.
  - lat_cnt decrements each edge.
  - On the edge where lat_cnt==0: capture alu_result into rsp_result, alu_zero into rsp_zero, set rsp_err=0, rsp_valid=1, go to RESP.
  - Latency with ALU_LAT=1: accept at edge E0, ALU registers at E1, rsp_valid rises after E2.
- RESP:
  - rsp_valid=1, and all rsp_* are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE.
  - A new request is accepted one cycle later at the earliest; there is no same-cycle turnaround.
- ALU outputs keep their last values in IDLE and RESP, so no spurious ALU activity occurs.
- Requester inputs are sampled only on the accept edge. Later changes to them have no effect.
- A requester dropping valid before being granted is legal; it simply loses arbitration.
- rsp_ready high while rsp_valid is low is ignored.
- Reset asserted mid-operation: any in-flight or pending response is discarded. The ALU's own register is not reset, and the arbiter never samples it outside EXEC.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.

Test Plan:
- Requester 0 sends add a=5, b=-7, rsp_ready=1 -> rsp_valid rises 2 cycles after accept; rsp_id=0, rsp_result=-2, rsp_zero=0, rsp_err=0.
- Both requesters hold valid; req0 sub 9-9, req1 slt a=-3, b=2; 4 operations issued -> grant order 0,1,0,1. Responses: result 0 with zero=1, and result 1 with zero=0.
- Requester 1 sends ctrl=4'h5 -> response on the cycle after accept with rsp_err=1, result=0; alu_a/alu_b/alu_ctrl unchanged.
- Requester 0 sends nor a=0, b=0 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result=-1 held stable; req0_ready and req1_ready stay 0; release when rsp_ready=1.
- rst_n pulsed low while in EXEC -> rsp_valid=0 immediately, state IDLE; next request from requester 0 is granted first.
- ALU_LAT=3 build with and a=48'hF0F0, b=48'hFF00 -> rsp_result=48'hF000 four cycles after accept; ALU inputs stable throughout.
